// File: rtl/spi_regfile_pkg.sv
// ============================================================================
// Module   : spi_regfile_pkg
// Brief    : Shared state encoding, opcodes and frame-width helper for the
//            SPI register-file peripheral.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Multi-flop synchroniser for an asynchronous pin with optional
//            rise/fall pulse outputs in the clk domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0,
    parameter bit EDGES   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
        end
    end

    assign level = r_sync[STAGES-1];

    generate
        if (EDGES) begin : g_edge
            logic r_prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev <= RST_VAL;
                end else begin
                    r_prev <= r_sync[STAGES-1];
                end
            end

            assign rise = r_sync[STAGES-1] & ~r_prev;
            assign fall = ~r_sync[STAGES-1] & r_prev;
        end else begin : g_level_only
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_regfile_peripheral.sv
// ============================================================================
// Module   : spi_regfile_peripheral
// Brief    : SPI mode-0 target writing a bank of control registers; CIPO
//            read-back is present only when SPI_READ_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic                         frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int HDR_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(HDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
    logic w_copi_lvl, w_unused_copi_rise, w_unused_copi_fall;
    logic w_unused_sclk_lvl;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );

    // ncs resets high so a pin already held high never produces a false start.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(w_ncs_lvl), .rise(w_ncs_rise), .fall(w_ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(w_copi_lvl), .rise(w_unused_copi_rise), .fall(w_unused_copi_fall)
    );

    assign w_unused_sclk_lvl = w_sclk_lvl;

    state_t                 r_state, w_next;
    logic                   r_start_pend;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_W-1:0]     r_rx;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_stb;
    logic                   r_frame_err;

    logic                   w_active, w_bit_rise, w_start;
    logic                   w_op, w_full, w_addr_ok, w_wr_ok, w_rd_ok;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_data;

    assign w_active   = (r_state == HDR) || (r_state == DATA);
    // A raised ncs also blocks any sclk edge landing in the same cycle.
    assign w_bit_rise = w_active && w_sclk_rise && !w_ncs_lvl;
    assign w_start    = (r_state == IDLE) && (w_next == HDR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if ((w_ncs_fall || r_start_pend) && !w_ncs_lvl) w_next = HDR;
            HDR:     if (w_ncs_rise) w_next = COMMIT;
                     else if (r_cnt == CNT_HDR) w_next = DATA;
            DATA:    if (w_ncs_rise) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_start_pend <= 1'b0;
            r_cnt        <= '0;
            r_rx         <= '0;
        end else begin
            r_state <= w_next;
            // Holds a select that arrives during COMMIT until IDLE can act on it.
            if (r_state == IDLE || w_ncs_rise) begin
                r_start_pend <= 1'b0;
            end else if (w_ncs_fall) begin
                r_start_pend <= 1'b1;
            end
            if (w_start) begin
                r_cnt <= '0;
                r_rx  <= '0;
            end else if (w_bit_rise) begin
                r_rx <= {r_rx[FRAME_W-2:0], w_copi_lvl};
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_op      = r_rx[FRAME_W-1];
    assign w_addr    = r_rx[DATA_W +: ADDR_W];
    assign w_data    = r_rx[DATA_W-1:0];
    assign w_full    = (r_cnt == CNT_FULL);
    assign w_addr_ok = ({1'b0, w_addr} < (ADDR_W+1)'(NUM_REGS));
    assign w_wr_ok   = w_full && (w_op == OP_WRITE) && w_addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_wr_stb    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_stb    <= '0;
            r_frame_err <= 1'b0;
            if (r_state == COMMIT) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_wr_ok && (w_addr == ADDR_W'(i))) begin
                        r_regs[i]   <= w_data;
                        r_wr_stb[i] <= 1'b1;
                    end
                end
                r_frame_err <= !(w_wr_ok || w_rd_ok);
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
            assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign wr_stb    = r_wr_stb;
    assign frame_err = r_frame_err;

`ifdef SPI_READ_EN
    logic [DATA_W-1:0] r_tx, w_rd_data;
    logic              r_cipo, w_bit_fall;

    assign w_rd_ok    = w_full && (w_op == OP_READ);
    assign w_bit_fall = (r_state == DATA) && w_sclk_fall && !w_ncs_lvl;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_rx[ADDR_W-1:0] == ADDR_W'(i)) w_rd_data = r_regs[i];
        end
    end

    // tx is loaded once the header is in, then presented MSB first on falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_start) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (r_state == HDR && w_next == DATA) begin
            r_tx <= (r_rx[ADDR_W] == OP_READ) ? w_rd_data : '0;
        end else if (w_bit_fall) begin
            r_cipo <= r_tx[DATA_W-1];
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo_oe = !w_ncs_lvl && (r_state != IDLE);
    assign cipo    = cipo_oe & r_cipo;
`else
    logic w_unused_sclk_fall;

    assign w_unused_sclk_fall = w_sclk_fall;
    assign w_rd_ok            = 1'b0;
    assign cipo_oe            = 1'b0;
    assign cipo               = 1'b0;
`endif

endmodule

`default_nettype wire
